// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad and emits one hex key
// code per debounced press.
//
// One column is driven low at a time. The rows are passed through a 2-flop
// synchronizer and sampled once at the end of every column dwell period.
// A single pressed key must be seen for DEBOUNCE_SCANS consecutive samples
// to be accepted. It must then be absent for the same number of samples to
// count as released. The column stays frozen while a key is being debounced
// or held.
//
// Parameters:
//   SCAN_DIV       clk cycles each column is driven before its rows are sampled (>= 4)
//   DEBOUNCE_SCANS consecutive identical samples to accept a press/release (>= 1)
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   row[3:0]   keypad rows, active-low, asynchronous to clk
//   col[3:0]   column drives, active-low, exactly one bit low
//   key_code   hex code of the last accepted key, held until the next press
//   key_valid  one-cycle pulse when a new press is accepted
//   key_down   high while the accepted key is held
module keypad_scanner #(
    parameter int SCAN_DIV       = 4000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    // Index of the (first) low bit in an active-low one-hot vector.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i] == 1'b0) begin
                idx = 2'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Number of low bits in the row vector.
    function automatic logic [2:0] count_low(input logic [3:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, ~v[i]};
        end
        return n;
    endfunction

    // Physical key layout: row r, column c -> hex code.
    function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'b00_00: k = 4'h1;
            4'b00_01: k = 4'h2;
            4'b00_10: k = 4'h3;
            4'b00_11: k = 4'hA;
            4'b01_00: k = 4'h4;
            4'b01_01: k = 4'h5;
            4'b01_10: k = 4'h6;
            4'b01_11: k = 4'hB;
            4'b10_00: k = 4'h7;
            4'b10_01: k = 4'h8;
            4'b10_10: k = 4'h9;
            4'b10_11: k = 4'hC;
            4'b11_00: k = 4'h0;
            4'b11_01: k = 4'hF;
            4'b11_10: k = 4'hE;
            4'b11_11: k = 4'hD;
            default:  k = 4'h0;
        endcase
        return k;
    endfunction

    logic [3:0]    sync1_r, row_s_r;
    logic [DW-1:0] dwell_r;
    logic          sample_tick_s;
    state_t        state_r, state_s;
    logic [3:0]    col_r, col_s;
    logic [CW-1:0] deb_r, deb_s, deb_inc_s;
    logic [3:0]    cand_r, cand_s, sample_key_s;
    logic [3:0]    code_r, code_s;
    logic          valid_r, valid_s;
    logic          down_r, down_s;
    logic          is_none_s, is_single_s;
    logic [3:0]    col_adv_s;

    // Two-flop synchronizer for the asynchronous row inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 4'b1111;
            row_s_r <= 4'b1111;
        end else begin
            sync1_r <= row;
            row_s_r <= sync1_r;
        end
    end

    // Column dwell counter. The column only ever changes on sample_tick,
    // so wrapping here is the same as restarting on every column change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_r <= '0;
        end else if (sample_tick_s) begin
            dwell_r <= '0;
        end else begin
            dwell_r <= dwell_r + DW'(1);
        end
    end

    assign sample_tick_s = (dwell_r == DW'(SCAN_DIV - 1));
    assign is_none_s     = (row_s_r == 4'b1111);
    assign is_single_s   = (count_low(row_s_r) == 3'd1);
    assign sample_key_s  = keymap(low_index(row_s_r), low_index(col_r));
    assign col_adv_s     = {col_r[2:0], col_r[3]};
    assign deb_inc_s     = deb_r + CW'(1);

    // State register plus all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= SCAN;
            col_r   <= 4'b1110;
            deb_r   <= '0;
            cand_r  <= 4'h0;
            code_r  <= 4'h0;
            valid_r <= 1'b0;
            down_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            col_r   <= col_s;
            deb_r   <= deb_s;
            cand_r  <= cand_s;
            code_r  <= code_s;
            valid_r <= valid_s;
            down_r  <= down_s;
        end
    end

    // Next-state logic. Decisions are taken only on sample_tick.
    always_comb begin
        state_s = state_r;
        col_s   = col_r;
        deb_s   = deb_r;
        cand_s  = cand_r;
        code_s  = code_r;
        valid_s = 1'b0;
        down_s  = down_r;
        if (sample_tick_s) begin
            case (state_r)
                SCAN: begin
                    if (is_single_s) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            code_s  = sample_key_s;
                            valid_s = 1'b1;
                            down_s  = 1'b1;
                            deb_s   = '0;
                            state_s = HELD;
                        end else begin
                            cand_s  = sample_key_s;
                            deb_s   = CW'(1);
                            state_s = DEBOUNCE;
                        end
                    end else begin
                        col_s = col_adv_s;
                    end
                end
                DEBOUNCE: begin
                    if (is_single_s && (sample_key_s == cand_r)) begin
                        if (deb_inc_s == CW'(DEBOUNCE_SCANS)) begin
                            code_s  = cand_r;
                            valid_s = 1'b1;
                            down_s  = 1'b1;
                            deb_s   = '0;
                            state_s = HELD;
                        end else begin
                            deb_s = deb_inc_s;
                        end
                    end else begin
                        deb_s   = '0;
                        col_s   = col_adv_s;
                        state_s = SCAN;
                    end
                end
                HELD: begin
                    // Any activity in the frozen column, including a second
                    // key, just restarts the release count.
                    if (is_none_s) begin
                        if (deb_inc_s == CW'(DEBOUNCE_SCANS)) begin
                            down_s  = 1'b0;
                            deb_s   = '0;
                            col_s   = col_adv_s;
                            state_s = SCAN;
                        end else begin
                            deb_s = deb_inc_s;
                        end
                    end else begin
                        deb_s = '0;
                    end
                end
                default: begin
                    deb_s   = '0;
                    down_s  = 1'b0;
                    col_s   = 4'b1110;
                    state_s = SCAN;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    assign col       = col_r;
    assign key_code  = code_r;
    assign key_valid = valid_r;
    assign key_down  = down_r;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

    logic       clk;
    logic       rst;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    logic [15:0] pressed;    // bit r*4+c = key at row r, column c held down
    logic [3:0]  exp_q[$];   // scoreboard of expected key_valid codes
    int          checks = 0;
    int          passes = 0;
    logic        prev_valid = 1'b0;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_down (key_down)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Keypad matrix model: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && (col[c] == 1'b0)) row[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every key_valid pulse must match the next expected code.
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_key_valid: got pulse with code %0h, expected none (t=%0t)",
                         key_code, $time);
            end else begin
                check("key_code_on_valid", {28'd0, key_code}, {28'd0, exp_q.pop_front()});
            end
            check("key_valid_one_cycle", {31'd0, prev_valid}, 32'd0);
        end
        prev_valid = key_valid;
    end

    task automatic wait_col(input string name, input logic [3:0] target, input int budget);
        int n;
        n = 0;
        while (col !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {28'd0, col}, {28'd0, target});
    endtask

    task automatic wait_down(input string name, input logic target, input int budget);
        int n;
        n = 0;
        while (key_down !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, key_down}, {31'd0, target});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] e;
        pressed = 16'h0000;
        rst     = 1'b1;
        repeat (3) @(negedge clk);

        // 1. Reset values and idle column rotation (4 cycles per column).
        check("rst_col",       {28'd0, col}, 32'h0000000E);
        check("rst_key_code",  {28'd0, key_code}, 32'd0);
        check("rst_key_valid", {31'd0, key_valid}, 32'd0);
        check("rst_key_down",  {31'd0, key_down}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            e = 4'b1110;
            for (int k = 0; k < (i / 4) % 4; k++) e = {e[2:0], e[3]};
            check("idle_col_rotation", {28'd0, col}, {28'd0, e});
            @(negedge clk);
        end

        // 2. Press '5' (row 1, column 1) and hold.
        pressed[1*4+1] = 1'b1;
        exp_q.push_back(4'h5);
        wait_down("press5_key_down", 1'b1, 100);
        check("press5_key_code", {28'd0, key_code}, 32'h5);
        check("press5_col_frozen", {28'd0, col}, 32'h0000000D);
        repeat (12) @(negedge clk);
        check("press5_col_still_frozen", {28'd0, col}, 32'h0000000D);

        // 3. Release: key_down drops and the column advances together.
        pressed = 16'h0000;
        wait_down("release5_key_down", 1'b0, 40);
        check("release5_col_advanced", {28'd0, col}, 32'h0000000B);
        check("release5_key_code_held", {28'd0, key_code}, 32'h5);

        // 4. Bounce on 'D' (row 3, column 3): seen for only two samples.
        pressed[3*4+3] = 1'b1;
        wait_col("bounce_reach_col3", 4'b0111, 40);
        repeat (8) @(negedge clk);
        pressed = 16'h0000;
        wait_col("bounce_resume_col0", 4'b1110, 12);
        check("bounce_key_code_kept", {28'd0, key_code}, 32'h5);
        check("bounce_key_down", {31'd0, key_down}, 32'd0);

        // 5. '2' and '8' together in column 1: multi, column keeps rotating.
        pressed[0*4+1] = 1'b1;
        pressed[2*4+1] = 1'b1;
        wait_col("multi_reach_col1", 4'b1101, 40);
        wait_col("multi_leave_col1", 4'b1011, 5);
        repeat (20) @(negedge clk);
        check("multi_key_down", {31'd0, key_down}, 32'd0);
        check("multi_key_code_kept", {28'd0, key_code}, 32'h5);
        pressed = 16'h0000;
        repeat (8) @(negedge clk);

        // 6. Asynchronous reset while holding 'A', then a fresh 'A' press.
        pressed[0*4+3] = 1'b1;
        exp_q.push_back(4'hA);
        wait_down("pressA_key_down", 1'b1, 100);
        check("pressA_key_code", {28'd0, key_code}, 32'hA);
        rst = 1'b1;
        #1;
        check("async_rst_col",       {28'd0, col}, 32'h0000000E);
        check("async_rst_key_code",  {28'd0, key_code}, 32'd0);
        check("async_rst_key_valid", {31'd0, key_valid}, 32'd0);
        check("async_rst_key_down",  {31'd0, key_down}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(4'hA);
        wait_down("repressA_key_down", 1'b1, 100);
        check("repressA_key_code", {28'd0, key_code}, 32'hA);
        pressed = 16'h0000;
        wait_down("releaseA_key_down", 1'b0, 40);
        repeat (10) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
